multiword_add_seq: RTL
======================

MULTIWORD_ADD_SEQ -- requirements
Module: multiword_add_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32: word width of the shared adder.
REQ-002 SHALL have parameter NWORDS, default 4 (legal range 2..16): number of words per operand.
REQ-003 SHALL have port clk_i, input, 1: the single clock.
REQ-004 SHALL have port rst_ni, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port req_valid_i, input, 1: request offered.
REQ-006 SHALL have port req_ready_o, output, 1: request accepted when high with req_valid_i.
REQ-007 SHALL have port req_sub_i, input, 1: 0 computes A+B, 1 computes A-B.
REQ-008 SHALL have ports req_a_i and req_b_i, input, WIDTH*NWORDS: operands, word 0 in the LSBs.
REQ-009 SHALL have port rsp_valid_o, output, 1: result available.
REQ-010 SHALL have port rsp_ready_i, input, 1: result consumed when high with rsp_valid_o.
REQ-011 SHALL have port rsp_sum_o, output, WIDTH*NWORDS: result.
REQ-012 SHALL have port rsp_cout_o, output, 1: final unsigned carry; for subtraction, 1 means no borrow.
REQ-013 SHALL have port rsp_ovf_o, output, 1: signed two's-complement overflow of the full-width operation.
REQ-014 SHALL have port busy_o, output, 1: high whenever the state is not IDLE.

Function
REQ-015 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-016 SHALL drive req_ready_o high only in IDLE; requests offered in RUN or DONE SHALL be ignored.
REQ-017 On acceptance (IDLE with req_valid_i high), SHALL:
- latch A;
- latch B, or ~B when req_sub_i is high;
- load the carry register with req_sub_i;
- clear the word index;
- enter RUN.
REQ-018 In RUN, SHALL process one word per cycle, LSW first, through a single WIDTH-bit adder:
- adder inputs are A word[idx], B word[idx] and the carry register;
- the sum goes to result word[idx];
- the adder carry-out goes to the carry register.
REQ-019 The word index SHALL count 0..NWORDS-1 with no wrap inside an operation; it SHALL clear on entry to DONE.
REQ-020 On the RUN cycle with idx = NWORDS-1, SHALL capture the adder cout into rsp_cout_o and the adder ovf into rsp_ovf_o, then enter DONE.
REQ-021 Latency: acceptance at cycle T SHALL give rsp_valid_o high at cycle T+NWORDS+1 (registered), independent of operand values.
REQ-022 In DONE, SHALL hold rsp_valid_o high, and hold rsp_sum_o, rsp_cout_o and rsp_ovf_o stable until rsp_ready_i is high.
REQ-023 On the DONE handshake, SHALL return to IDLE in the next cycle; a new request is accepted no earlier than the cycle after that.
REQ-024 Operand inputs SHALL need to be stable only in the acceptance cycle.
REQ-025 rsp_sum_o, rsp_cout_o and rsp_ovf_o SHALL keep the last result while in IDLE, until the next DONE result overwrites them.
REQ-026 Overflow SHALL depend only on the MSB word (signs of A, B-or-~B and the sum); carries from lower words SHALL affect it only through the chained carry.

Reset
REQ-027 When rst_ni is low at a clock edge, SHALL enter IDLE and clear all of:
- the index, carry, operand and result registers;
- rsp_valid_o, rsp_cout_o, rsp_ovf_o and busy_o.
REQ-028 req_ready_o SHALL be high in the first cycle after rst_ni is released.
REQ-029 A reset asserted mid-RUN or mid-DONE SHALL abort the operation with no response, and no carry SHALL leak into the next operation.

Structure
REQ-030 A shared package SHALL hold the FSM state enum (IDLE/RUN/DONE) and the default WIDTH/NWORDS constants.
REQ-031 SHALL instantiate exactly one ADDER_WITH_CARRY sub-module (WIDTH = WIDTH) as the shared datapath; no other adder SHALL be inferred for operand words.
REQ-032 The index counter width SHALL be $clog2(NWORDS).

Verification (WIDTH=32, NWORDS=4)
REQ-033 Carry chaining: add A=0x...0000_FFFFFFFF, B=1 -> sum 0x0000_0000_0000_0000_0000_0001_0000_0000, cout 0, ovf 0, rsp_valid 5 cycles after acceptance.
REQ-034 Wrap to zero: A=all-ones, B=1, add -> sum 0, cout 1, ovf 0.
REQ-035 Signed overflow: A=0x7FFF...FFFF, B=1, add -> sum 0x8000...0000, cout 0, ovf 1; subtraction 0-1 -> all-ones, cout 0, ovf 0.
REQ-036 Backpressure: hold rsp_ready_i low 3 cycles in DONE while driving req_valid_i high -> outputs stable, req_ready_o 0, no second acceptance; handshake then IDLE.
REQ-037 Reset mid-operation: pulse rst_ni low at idx=2 of all-ones+1 -> next cycle all outputs 0, req_ready_o 1; a following 5+3 add -> sum 8, cout 0.

Source files
------------

// File: rtl/multiword_add_seq_pkg.sv
// Shared types and default sizing for the multi-word sequential adder.
// Holds the control FSM encoding used by multiword_add_seq.
package multiword_add_seq_pkg;

    localparam int unsigned DEF_WIDTH  = 32;
    localparam int unsigned DEF_NWORDS = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/multiword_add_seq_adder.sv
// Single-word adder with carry in/out and signed-overflow flag.
// This is the one shared datapath adder stepped across the operand words.
module multiword_add_seq_adder #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign sum  = full[WIDTH-1:0];
    assign cout = full[WIDTH];
    // Overflow only meaningful on the most significant word; caller decides when to use it.
    assign ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/multiword_add_seq.sv
// Multi-word add/subtract, one WIDTH-bit word per cycle, LSW first.
// Result registers hold the last completed operation until the next one finishes.
module multiword_add_seq
    import multiword_add_seq_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned NWORDS = DEF_NWORDS
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_sub_i,
    input  logic [WIDTH*NWORDS-1:0] req_a_i,
    input  logic [WIDTH*NWORDS-1:0] req_b_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [WIDTH*NWORDS-1:0] rsp_sum_o,
    output logic                    rsp_cout_o,
    output logic                    rsp_ovf_o,
    output logic                    busy_o
);

    localparam int unsigned IDXW = $clog2(NWORDS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

    state_t state_q, state_d;

    logic [NWORDS-1:0][WIDTH-1:0] a_q, b_q, res_q, res_next, rsp_sum_q;
    logic [IDXW-1:0]              idx_q;
    logic                         carry_q;
    logic                         rsp_cout_q, rsp_ovf_q;

    logic [WIDTH-1:0] add_sum;
    logic             add_cout, add_ovf;
    logic             accept, last_word;

    multiword_add_seq_adder #(.WIDTH(WIDTH)) u_adder (
        .a    (a_q[idx_q]),
        .b    (b_q[idx_q]),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout),
        .ovf  (add_ovf)
    );

    assign accept    = (state_q == IDLE) && req_valid_i;
    assign last_word = (state_q == RUN) && (idx_q == LAST_IDX);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid_i) state_d = RUN;
            RUN:     if (idx_q == LAST_IDX) state_d = DONE;
            DONE:    if (rsp_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The final word is merged here so the published result updates in one step at DONE entry.
    always_comb begin
        res_next         = res_q;
        res_next[idx_q]  = add_sum;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            rsp_sum_q  <= '0;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            rsp_cout_q <= 1'b0;
            rsp_ovf_q  <= 1'b0;
        end else if (accept) begin
            a_q     <= req_a_i;
            b_q     <= req_sub_i ? ~req_b_i : req_b_i;
            carry_q <= req_sub_i;
            idx_q   <= '0;
        end else if (state_q == RUN) begin
            res_q   <= res_next;
            carry_q <= add_cout;
            if (last_word) begin
                idx_q      <= '0;
                rsp_sum_q  <= res_next;
                rsp_cout_q <= add_cout;
                rsp_ovf_q  <= add_ovf;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    assign req_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign rsp_sum_o   = rsp_sum_q;
    assign rsp_cout_o  = rsp_cout_q;
    assign rsp_ovf_o   = rsp_ovf_q;

endmodule
